// File: rtl/clk_pkg.sv
// Shared types and default sizes for the clock-enable generator.
package clk_pkg;

  localparam int unsigned CHANNELS_DEF  = 4;
  localparam int unsigned ACC_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_RUN       = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/frac_div_chan.sv
// One fractional clock-enable channel: phase accumulator stepping by num, wrapping at den.
module frac_div_chan
  import clk_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 advance_i,
  input  logic [ACC_WIDTH-1:0] num_i,
  input  logic [ACC_WIDTH-1:0] den_i,
  output logic                 clk_en_o
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 en_q, en_d;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH:0]   diff;

  assign sum  = {1'b0, acc_q} + {1'b0, num_i};
  assign diff = sum - {1'b0, den_i};

  // When not advancing the accumulator is parked at zero so every channel restarts in phase.
  always_comb begin
    acc_d = '0;
    en_d  = 1'b0;
    if (advance_i && (den_i != '0)) begin
      if (num_i >= den_i) begin
        en_d = 1'b1;
      end else if (sum >= {1'b0, den_i}) begin
        acc_d = diff[ACC_WIDTH-1:0];
        en_d  = 1'b1;
      end else begin
        acc_d = sum[ACC_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      en_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      en_q  <= en_d;
    end
  end

  assign clk_en_o = en_q;

endmodule

// File: rtl/clk_enable_gen.sv
// PLL-lock gated sequencer driving CHANNELS fractional clock-enable generators.
//
//  state        | meaning
//  -------------+-----------------------------------------------------------
//  ST_WAIT_LOCK | waiting for synchronised lock; outputs held off
//  ST_SETTLE    | lock seen, counting down SETTLE_CYCLES of stable lock
//  ST_RUN       | downstream reset released, enables running
module clk_enable_gen
  import clk_pkg::*;
#(
  parameter int unsigned CHANNELS      = CHANNELS_DEF,
  parameter int unsigned ACC_WIDTH     = ACC_WIDTH_DEF,
  parameter int unsigned SETTLE_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          locked,
  input  logic [CHANNELS*ACC_WIDTH-1:0] cfg_num,
  input  logic [CHANNELS*ACC_WIDTH-1:0] cfg_den,
  input  logic                          cfg_load,
  output logic [CHANNELS-1:0]           clk_en,
  output logic                          rst_out_n,
  output logic                          ready
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic                          sync1_q, locked_s_q;
  fsm_state_e                    state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          ready_q, rst_out_q;
  logic [CHANNELS*ACC_WIDTH-1:0] num_q, den_q;
  logic                          advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= locked;
      locked_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (!locked_s_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s_q) state_d = ST_WAIT_LOCK;
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // ready/rst_out follow the next state so they are high on exactly the RUN cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_WAIT_LOCK;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      rst_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= (state_d == ST_RUN);
      rst_out_q <= (state_d == ST_RUN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q <= '0;
      den_q <= '0;
    end else if (cfg_load) begin
      num_q <= cfg_num;
      den_q <= cfg_den;
    end
  end

  // A load or the first RUN cycle clears all accumulators together.
  assign advance = (state_q == ST_RUN) && (state_d == ST_RUN) && !cfg_load;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    frac_div_chan #(
      .ACC_WIDTH (ACC_WIDTH)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance_i (advance),
      .num_i     (num_q[i*ACC_WIDTH +: ACC_WIDTH]),
      .den_i     (den_q[i*ACC_WIDTH +: ACC_WIDTH]),
      .clk_en_o  (clk_en[i])
    );
  end

  assign ready     = ready_q;
  assign rst_out_n = rst_out_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Randomised bench for clk_enable_gen against a rate/lock-history reference model.
module tb_clk_enable_gen;

  localparam int CH = 4;
  localparam int AW = 16;
  localparam int S  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              locked;
  logic [CH*AW-1:0]  cfg_num, cfg_den;
  logic              cfg_load;
  logic [CH-1:0]     clk_en;
  logic              rst_out_n;
  logic              ready;

  int n_checks, n_err;

  // reference model state
  logic              m_d1, m_d2;
  int                run_len;
  logic              m_run;
  longint            m_n;
  logic [AW-1:0]     m_num [CH];
  logic [AW-1:0]     m_den [CH];
  logic [CH-1:0]     m_en;

  clk_enable_gen #(
    .CHANNELS      (CH),
    .ACC_WIDTH     (AW),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .locked    (locked),
    .cfg_num   (cfg_num),
    .cfg_den   (cfg_den),
    .cfg_load  (cfg_load),
    .clk_en    (clk_en),
    .rst_out_n (rst_out_n),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse n (1-based) of a num/den rate: fires whenever floor(n*num/den) steps up.
  function automatic logic exp_pulse(input longint n, input longint num, input longint den);
    if (den == 0) return 1'b0;
    if (num >= den) return 1'b1;
    return ((n * num) / den) != (((n - 1) * num) / den);
  endfunction

  task automatic model_reset();
    m_d1 = 1'b0; m_d2 = 1'b0; run_len = 0; m_run = 1'b0; m_n = 0; m_en = '0;
    for (int c = 0; c < CH; c++) begin
      m_num[c] = '0;
      m_den[c] = '0;
    end
  endtask

  // RUN == the last S+1 synchronised lock samples were all high.
  task automatic model_step();
    logic ls, was, adv;
    if (!rst_n) begin
      model_reset();
    end else begin
      ls = m_d2; m_d2 = m_d1; m_d1 = locked;
      run_len = ls ? ((run_len < 1000) ? run_len + 1 : run_len) : 0;
      was   = m_run;
      m_run = (run_len >= S + 1);
      adv   = was && m_run && !cfg_load;
      if (adv) begin
        m_n++;
        for (int c = 0; c < CH; c++)
          m_en[c] = exp_pulse(m_n, longint'(m_num[c]), longint'(m_den[c]));
      end else begin
        m_n  = 0;
        m_en = '0;
      end
      if (cfg_load) begin
        for (int c = 0; c < CH; c++) begin
          m_num[c] = cfg_num[c*AW +: AW];
          m_den[c] = cfg_den[c*AW +: AW];
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("ready", ready, m_run);
    chk("rst_out_n", rst_out_n, m_run);
    chk("clk_en", clk_en, m_en);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic set_cfg(input int c, input logic [AW-1:0] num, input logic [AW-1:0] den);
    cfg_num[c*AW +: AW] = num;
    cfg_den[c*AW +: AW] = den;
  endtask

  task automatic load_cfg();
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (!ready && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic rand_chan(input int c);
    logic [AW-1:0] n, d;
    case ($urandom_range(0, 5))
      0: begin d = '0; n = AW'($urandom_range(0, 20)); end
      1: begin n = '0; d = AW'($urandom_range(1, 20)); end
      2: begin d = AW'($urandom_range(1, 10)); n = d + AW'($urandom_range(0, 50)); end
      5: begin n = AW'($urandom); d = AW'($urandom); end
      default: begin d = AW'($urandom_range(2, 20)); n = AW'($urandom_range(1, 19)) % d; end
    endcase
    set_cfg(c, n, d);
  endtask

  int lat, c0, c1, c2, c3;

  initial begin
    n_checks = 0; n_err = 0;
    rst_n = 1'b1; locked = 1'b0; cfg_load = 1'b0; cfg_num = '0; cfg_den = '0;
    model_reset();
    @(negedge clk);
    do_reset();
    tick();
    tick();

    set_cfg(0, 1, 3); set_cfg(1, 1, 16); set_cfg(2, 5, 8); set_cfg(3, 7, 0);
    load_cfg();

    locked = 1'b1;
    wait_ready(lat);
    chk("lock_latency", lat, 7);

    c0 = 0;
    for (int k = 0; k < 300; k++) begin tick(); c0 += int'(clk_en[0]); end
    chk("ch0_1of3_pulses", c0, 100);

    c1 = 0; c2 = 0; c3 = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      c1 += int'(clk_en[1]); c2 += int'(clk_en[2]); c3 += int'(clk_en[3]);
    end
    chk("ch1_1of16_tol", (c1 >= 61 && c1 <= 63), 1);
    chk("ch2_5of8_tol", (c2 >= 624 && c2 <= 626), 1);
    chk("ch3_den0_pulses", c3, 0);

    set_cfg(0, 1, 2);
    load_cfg();
    chk("load_run_all_zero", clk_en, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("half_pattern", clk_en[0], k % 2);
    end

    locked = 1'b0;
    tick();
    tick();
    set_cfg(0, 3, 7); set_cfg(1, 2, 5); set_cfg(2, 9, 9); set_cfg(3, 4, 0);
    load_cfg();
    chk("lockloss_ready", ready, 0);
    chk("lockloss_rst_out", rst_out_n, 0);
    chk("lockloss_en", clk_en, 0);

    locked = 1'b1;
    tick();
    tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    wait_ready(lat);
    chk("resettle_latency", lat, 7);

    c0 = 0; c2 = 0; c3 = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      c0 += int'(clk_en[0]); c2 += int'(clk_en[2]); c3 += int'(clk_en[3]);
    end
    chk("ch0_3of7_pulses", c0, (200 * 3) / 7);
    chk("ch2_full_rate", c2, 200);
    chk("ch3_den0_after_load", c3, 0);

    do_reset();
    chk("reset_clears_ready", ready, 0);

    locked = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 999) < 2) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 999) < 10) locked = ~locked;
        if ($urandom_range(0, 99) < 3) begin
          for (int c = 0; c < CH; c++) rand_chan(c);
          cfg_load = 1'b1;
        end
        tick();
        cfg_load = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/clk_enable_gen.md
CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent clock-enable channels (1..8).
REQ-002 Parameter ACC_WIDTH, default 16: width of each channel's numerator, denominator and accumulator.
REQ-003 Parameter SETTLE_CYCLES, default 1024: cycles of stable lock required before release (>=1).
REQ-004 clk  input  1  single system clock (PLL output, e.g. 96 MHz); all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 locked  input  1  PLL lock indication, asynchronous to clk.
REQ-007 cfg_num  input  CHANNELS*ACC_WIDTH  per-channel numerator; channel i occupies bits [i*ACC_WIDTH +: ACC_WIDTH].
REQ-008 cfg_den  input  CHANNELS*ACC_WIDTH  per-channel denominator, same packing.
REQ-009 cfg_load  input  1  one-cycle strobe that latches cfg_num/cfg_den.
REQ-010 clk_en  output  CHANNELS  registered per-channel clock-enable pulses, one clk cycle wide.
REQ-011 rst_out_n  output  1  registered active-low reset for downstream logic; released only in RUN.
REQ-012 ready  output  1  registered; high exactly while in RUN.

Function
REQ-013 locked shall pass through a 2-flop synchroniser (locked_s); only locked_s is used internally.
REQ-014 The FSM shall have states WAIT_LOCK, SETTLE and RUN, encoded as a 2-bit enum.
REQ-015 WAIT_LOCK -> SETTLE when locked_s=1, loading the settle counter with SETTLE_CYCLES-1.
REQ-016 SETTLE: the counter decrements each cycle; when it is 0 with locked_s=1 -> RUN; locked_s=0 at any cycle -> WAIT_LOCK.
REQ-017 RUN -> WAIT_LOCK on locked_s=0; lock loss takes priority over every other event.
REQ-018 rst_out_n and ready shall be 1 from the first RUN cycle and return to 0 on the cycle after the FSM leaves RUN.
REQ-019 cfg_load shall latch cfg_num/cfg_den into shadow registers in any state; the shadows drive the accumulators.
REQ-020 Per channel, in RUN: sum = acc + num at ACC_WIDTH+1 bits; if sum >= den then acc <= sum - den and clk_en <= 1, else acc <= sum and clk_en <= 0.
REQ-021 Long-run pulse rate shall be exactly num/den of clk, e.g. num=1 den=16 gives 6 MHz from 96 MHz, and num=1 den=3 gives 32 MHz.
REQ-022 den=0 shall disable the channel: clk_en=0 and acc held at 0.
REQ-023 num=0 shall give clk_en permanently 0.
REQ-024 num>=den with den>0 shall give clk_en=1 every RUN cycle, with acc held at 0.
REQ-025 Outside RUN: every acc shall be 0 and clk_en shall be all-zero.
REQ-026 cfg_load in RUN: the new shadows shall take effect next cycle, all accumulators shall clear to 0 together (phase-aligned restart), and clk_en shall be 0 on that cycle.
REQ-027 cfg_load coinciding with lock loss: the shadows shall still be latched and the FSM shall go to WAIT_LOCK.

Reset
REQ-028 On rst_n=0, asynchronously: state=WAIT_LOCK, synchroniser=0, settle counter=0, acc=0, clk_en=0, rst_out_n=0, ready=0.
REQ-029 Shadow registers shall reset to num=0, den=0 (all channels disabled until the first cfg_load).
REQ-030 Reset deassertion mid-operation shall restart from WAIT_LOCK; no state survives reset.

Structure
REQ-031 The FSM state enum and the default ACC_WIDTH/CHANNELS constants shall reside in the shared package clk_pkg.
REQ-032 The per-channel accumulator and compare logic shall be one sub-module, frac_div_chan, instantiated CHANNELS times by generate.

Verification
REQ-033 Scenario: reset release, locked=1, SETTLE_CYCLES=4 -> ready and rst_out_n rise on exactly the 7th clk after locked rises (2 sync + 4 settle + 1 registered output).
REQ-034 Scenario: ch0 num=1 den=3 in RUN from acc=0 -> clk_en[0] pattern 0,0,1 repeating; over 300 cycles, exactly 100 pulses.
REQ-035 Scenario: ch1 num=1 den=16, ch2 num=5 den=8 -> 1000 cycles give 62 and 625 pulses respectively (+/-1).
REQ-036 Scenario: locked drops for 1 synchronised cycle during SETTLE with count=2 -> return to WAIT_LOCK; the full SETTLE_CYCLES is re-counted after lock returns.
REQ-037 Scenario: cfg_load in RUN changes ch0 from 1/3 to 1/2 -> clk_en=0 on the cycle after the load, then the 0,1 pattern from acc=0.
REQ-038 Scenario: locked=0 in RUN, simultaneous with cfg_load; separately, den=0 on one channel -> rst_out_n/ready low and all clk_en 0 within 3 cycles with the shadows updated; the den=0 channel stays 0 throughout.
